three_row_reader: RTL and testbench

//  Consumer side of the four-RAM row buffer. The buffer concatenates 3 rows into
//  M_Data and announces each ready row-triple with Start_Row. This block answers with

---
 rtl/three_row_reader_pkg.sv | 15 +
 rtl/row3_out_fifo.sv | 55 +++++
 rtl/three_row_reader.sv | 170 +++++++++++++++++
 tb/tb_three_row_reader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/three_row_reader_pkg.sv
// Shared constants and FSM type for the three-row reader and its output FIFO.
// ROWBUF_RD_LAT must match the latency the row-buffer writer side assumes.
package three_row_reader_pkg;

  localparam int unsigned WIDTH_DATA    = 8;
  localparam int unsigned PICTURE_NUM   = 1;
  localparam int unsigned ROWBUF_RD_LAT = 2;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } state_e;

endpackage

// File: rtl/row3_out_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and synchronous flush.
// The output reads as zero while the FIFO is empty.
module row3_out_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);
  assign count    = count_q;
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/three_row_reader.sv
// Consumer of the four-RAM row buffer: sweeps the 3-row window column-major and streams
// column vectors to the PE array through a credit-protected FWFT FIFO.
module three_row_reader
  import three_row_reader_pkg::*;
#(
  parameter int unsigned CHANNEL_IN_NUM     = 16,
  parameter int unsigned WIDTH_RAM_SIZE     = 10,
  parameter int unsigned WIDTH_FEATURE_SIZE = 12,
  parameter int unsigned WIDTH_CHANNEL_NUM  = 10,
  parameter int unsigned RD_LAT             = ROWBUF_RD_LAT,
  parameter int unsigned FIFO_DEPTH         = 4,
  localparam int unsigned DW = WIDTH_DATA * PICTURE_NUM * CHANNEL_IN_NUM * 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          Next_Reg,
  input  logic                          Start,
  input  logic [WIDTH_FEATURE_SIZE-1:0] Row_Num_After_Padding,
  input  logic [WIDTH_CHANNEL_NUM-1:0]  Channel_In_Num_REG,
  input  logic                          Start_Row,
  output logic                          M_Ready,
  output logic [WIDTH_RAM_SIZE-1:0]     M_Addr,
  input  logic [DW-1:0]                 M_Data,
  output logic [DW-1:0]                 O_Data,
  output logic                          O_Valid,
  input  logic                          O_Ready,
  output logic                          O_Last,
  output logic                          Row_Done,
  output logic                          Layer_Done,
  output logic                          Proto_Err
);

  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CT_SHIFT = $clog2(CHANNEL_IN_NUM);

  state_e                        state_q;
  logic [WIDTH_FEATURE_SIZE-1:0] col_q, row_cnt_q;
  logic [WIDTH_CHANNEL_NUM-1:0]  cin_q;
  logic [WIDTH_RAM_SIZE-1:0]     addr_q, out_cnt_q;
  logic [RD_LAT-1:0]             vld_q;
  logic                          m_ready_q, row_done_q, layer_done_q, proto_err_q;

  logic [WIDTH_FEATURE_SIZE-1:0] w;
  logic [WIDTH_CHANNEL_NUM-1:0]  ct_raw, ct;
  logic [WIDTH_RAM_SIZE-1:0]     total;
  logic [CNT_W-1:0]              fifo_count;
  logic                          fifo_empty;
  logic [DW-1:0]                 fifo_data;
  int unsigned                   in_flight;
  logic                          issue, last_issue, accept, last_vec, accept_last, layer_end;

  always_comb begin
    w      = Row_Num_After_Padding;
    ct_raw = Channel_In_Num_REG >> CT_SHIFT;
    ct     = (ct_raw == '0) ? WIDTH_CHANNEL_NUM'(1) : ct_raw;
    total  = WIDTH_RAM_SIZE'(w * ct);
    in_flight = 0;
    for (int i = 0; i < int'(RD_LAT); i++) begin
      if (vld_q[i]) in_flight++;
    end
    // Occupancy plus reads in flight bounds what the FIFO may have to absorb.
    issue       = (state_q == StIssue) && (32'(fifo_count) + in_flight < FIFO_DEPTH);
    last_issue  = issue && (col_q == w - WIDTH_FEATURE_SIZE'(1))
                        && (cin_q == ct - WIDTH_CHANNEL_NUM'(1));
    accept      = !fifo_empty && O_Ready;
    last_vec    = !fifo_empty && (out_cnt_q == total - WIDTH_RAM_SIZE'(1));
    accept_last = accept && last_vec;
    layer_end   = (row_cnt_q + WIDTH_FEATURE_SIZE'(1)) == (w - WIDTH_FEATURE_SIZE'(2));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      col_q        <= '0;
      cin_q        <= '0;
      addr_q       <= '0;
      out_cnt_q    <= '0;
      row_cnt_q    <= '0;
      vld_q        <= '0;
      m_ready_q    <= 1'b0;
      row_done_q   <= 1'b0;
      layer_done_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else if (Next_Reg) begin
      state_q      <= StIdle;
      col_q        <= '0;
      cin_q        <= '0;
      addr_q       <= '0;
      out_cnt_q    <= '0;
      row_cnt_q    <= '0;
      vld_q        <= '0;
      m_ready_q    <= 1'b0;
      row_done_q   <= 1'b0;
      layer_done_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      vld_q        <= RD_LAT'({vld_q, issue});
      row_done_q   <= accept_last;
      layer_done_q <= accept_last && layer_end;
      if (accept) out_cnt_q <= accept_last ? '0 : out_cnt_q + WIDTH_RAM_SIZE'(1);
      if (Start) begin
        row_cnt_q <= '0;
      end else if (accept_last) begin
        row_cnt_q <= layer_end ? '0 : row_cnt_q + WIDTH_FEATURE_SIZE'(1);
      end
      unique case (state_q)
        StIdle: begin
          addr_q <= '0;
          if (Start_Row) begin
            state_q   <= StIssue;
            m_ready_q <= 1'b1;
            col_q     <= '0;
            cin_q     <= '0;
          end
        end
        StIssue: begin
          if (Start_Row) proto_err_q <= 1'b1;
          if (last_issue) begin
            state_q <= StDrain;
            addr_q  <= '0;
            col_q   <= '0;
            cin_q   <= '0;
          end else if (issue) begin
            addr_q <= addr_q + WIDTH_RAM_SIZE'(1);
            if (cin_q == ct - WIDTH_CHANNEL_NUM'(1)) begin
              cin_q <= '0;
              col_q <= col_q + WIDTH_FEATURE_SIZE'(1);
            end else begin
              cin_q <= cin_q + WIDTH_CHANNEL_NUM'(1);
            end
          end
        end
        StDrain: begin
          if (Start_Row) proto_err_q <= 1'b1;
          // Hold the window until every vector of this row has left the FIFO.
          if ((vld_q == '0) && fifo_empty) begin
            state_q   <= StIdle;
            m_ready_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  row3_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (Next_Reg),
    .push      (vld_q[RD_LAT-1]),
    .push_data (M_Data),
    .pop       (O_Ready),
    .pop_data  (fifo_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign M_Ready    = m_ready_q;
  assign M_Addr     = addr_q;
  assign O_Data     = fifo_data;
  assign O_Valid    = !fifo_empty;
  assign O_Last     = last_vec;
  assign Row_Done   = row_done_q;
  assign Layer_Done = layer_done_q;
  assign Proto_Err  = proto_err_q;

endmodule

// File: tb/tb_three_row_reader.sv
// Directed bench for three_row_reader: models the row buffer's read pipeline and checks
// address sweep, vector order, credit bound, handshake and done/error flags.
module tb_three_row_reader;
  import three_row_reader_pkg::*;

  localparam int unsigned DW    = WIDTH_DATA * PICTURE_NUM * 16 * 3;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          Next_Reg, Start, Start_Row, O_Ready;
  logic [11:0]   Row_Num_After_Padding;
  logic [9:0]    Channel_In_Num_REG;
  logic          M_Ready, O_Valid, O_Last, Row_Done, Layer_Done, Proto_Err;
  logic [9:0]    M_Addr;
  logic [DW-1:0] M_Data, O_Data;

  logic [7:0]    tag;
  logic [9:0]    d1_q, d2_q;

  int n_checks = 0;
  int n_fail   = 0;

  int r_acc, r_lastcnt, r_last_err, r_data_err, r_addr_err, r_over, r_early, r_hold_err;
  int r_rowdone, r_layerdone, r_timeout, r_mready_t1;

  three_row_reader dut (
    .clk                   (clk),
    .rst                   (rst),
    .Next_Reg              (Next_Reg),
    .Start                 (Start),
    .Row_Num_After_Padding (Row_Num_After_Padding),
    .Channel_In_Num_REG    (Channel_In_Num_REG),
    .Start_Row             (Start_Row),
    .M_Ready               (M_Ready),
    .M_Addr                (M_Addr),
    .M_Data                (M_Data),
    .O_Data                (O_Data),
    .O_Valid               (O_Valid),
    .O_Ready               (O_Ready),
    .O_Last                (O_Last),
    .Row_Done              (Row_Done),
    .Layer_Done            (Layer_Done),
    .Proto_Err             (Proto_Err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_data(input logic [7:0] t, input logic [9:0] a);
    logic [DW-1:0] r;
    r = '0;
    r[DW-1 -: 8] = 8'hA5;
    r[17:10]     = t;
    r[9:0]       = a;
    return r;
  endfunction

  // Row buffer: RAM read register plus output register.
  always @(posedge clk) begin
    d1_q <= M_Addr;
    d2_q <= d1_q;
  end
  assign M_Data = exp_data(tag, d2_q);

  task automatic check(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic pulse(input int which);
    @(negedge clk);
    if (which == 0) Start = 1'b1; else Next_Reg = 1'b1;
    @(negedge clk);
    Start    = 1'b0;
    Next_Reg = 1'b0;
  endtask

  task automatic do_row(input int t, input int total, input int duty, input bit inject);
    int k, issued, accepted;
    logic [9:0] prev_addr;
    logic [DW-1:0] held;
    bit stall, done;
    tag = t[7:0];
    r_lastcnt = 0; r_last_err = 0; r_data_err = 0; r_addr_err = 0; r_over = 0;
    r_early = 0; r_hold_err = 0; r_rowdone = 0; r_layerdone = 0; r_mready_t1 = 0;
    @(negedge clk);
    prev_addr = M_Addr;
    Start_Row = 1'b1;
    k = 0; issued = 0; accepted = 0; stall = 0; done = 0; held = '0;
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
      Start_Row = inject && (k == 3);
      if (k == 1) r_mready_t1 = int'(M_Ready);
      if (M_Addr !== prev_addr) issued++;
      prev_addr = M_Addr;
      if (k <= total && M_Addr !== 10'(k - 1)) r_addr_err++;
      if (issued - accepted > DEPTH) r_over++;
      if (stall && O_Data !== held) r_hold_err++;
      if (Row_Done === 1'b1) r_rowdone++;
      if (Layer_Done === 1'b1) r_layerdone++;
      if (k > 1 && M_Ready !== 1'b1) begin
        if (accepted < total) r_early++;
        done = 1;
      end
      O_Ready = (k % duty == 0);
      if (O_Valid === 1'b1 && O_Ready) begin
        if (O_Data !== exp_data(tag, 10'(accepted))) r_data_err++;
        if (O_Last !== (accepted == total - 1)) r_last_err++;
        if (O_Last === 1'b1) r_lastcnt++;
        accepted++;
      end
      stall = (O_Valid === 1'b1) && !O_Ready;
      held  = O_Data;
    end
    O_Ready   = 1'b1;
    r_acc     = accepted;
    r_timeout = done ? 0 : 1;
  endtask

  task automatic check_row(input string n, input int total, input int exp_layer, input bit ca);
    check({n, " timeout"}, r_timeout, 0);
    check({n, " mready_t1"}, r_mready_t1, 1);
    check({n, " accepted"}, r_acc, total);
    check({n, " data_err"}, r_data_err, 0);
    check({n, " last_cnt"}, r_lastcnt, 1);
    check({n, " last_err"}, r_last_err, 0);
    check({n, " row_done"}, r_rowdone, 1);
    check({n, " layer_done"}, r_layerdone, exp_layer);
    check({n, " over_credit"}, r_over, 0);
    check({n, " mready_early"}, r_early, 0);
    check({n, " hold_err"}, r_hold_err, 0);
    if (ca) check({n, " addr_err"}, r_addr_err, 0);
    check({n, " idle_valid"}, O_Valid, 0);
  endtask

  initial begin
    bit found;
    rst = 1'b0; Next_Reg = 1'b0; Start = 1'b0; Start_Row = 1'b0; O_Ready = 1'b1;
    Row_Num_After_Padding = 12'd5;
    Channel_In_Num_REG    = 10'd32;
    tag = 8'h00;
    repeat (3) @(negedge clk);
    check("rst M_Ready", M_Ready, 0);
    check("rst M_Addr", M_Addr, 0);
    check("rst O_Valid", O_Valid, 0);
    check("rst O_Data", O_Data, 0);
    check("rst O_Last", O_Last, 0);
    check("rst Row_Done", Row_Done, 0);
    check("rst Layer_Done", Layer_Done, 0);
    check("rst Proto_Err", Proto_Err, 0);
    rst = 1'b1;

    // W=5, CT=2, always ready: addresses 0..9 back to back.
    do_row(8'h11, 10, 1, 1'b0);
    check_row("t1", 10, 0, 1'b1);
    check("t1 proto_err", Proto_Err, 0);

    // 1-of-3 ready duty exercises the credit limit.
    pulse(0);
    do_row(8'h22, 10, 3, 1'b0);
    check_row("t2", 10, 0, 1'b0);

    // Start_Row during ISSUE is ignored but flagged until Next_Reg.
    do_row(8'h33, 10, 1, 1'b1);
    check_row("t5", 10, 0, 1'b1);
    check("t5 proto_err set", Proto_Err, 1);
    repeat (3) @(negedge clk);
    check("t5 proto_err sticky", Proto_Err, 1);
    pulse(1);
    check("t5 proto_err cleared", Proto_Err, 0);

    // W=4, CT=1: a layer is two rows.
    Row_Num_After_Padding = 12'd4;
    Channel_In_Num_REG    = 10'd16;
    pulse(0);
    do_row(8'h41, 4, 1, 1'b0);
    check_row("t4 r1", 4, 0, 1'b1);
    do_row(8'h42, 4, 1, 1'b0);
    check_row("t4 r2", 4, 1, 1'b1);
    do_row(8'h43, 4, 1, 1'b0);
    check_row("t4 r3", 4, 0, 1'b1);
    do_row(8'h44, 4, 2, 1'b0);
    check_row("t4 r4", 4, 1, 1'b0);

    // Asynchronous reset in the middle of a row.
    Row_Num_After_Padding = 12'd5;
    Channel_In_Num_REG    = 10'd32;
    tag = 8'h55;
    @(negedge clk);
    Start_Row = 1'b1;
    @(negedge clk);
    Start_Row = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (M_Addr === 10'd3) found = 1;
      else @(negedge clk);
    end
    check("t6 reach addr3", found, 1);
    rst = 1'b0;
    #1;
    check("t6 async M_Ready", M_Ready, 0);
    @(negedge clk);
    check("t6 M_Ready", M_Ready, 0);
    check("t6 O_Valid", O_Valid, 0);
    check("t6 M_Addr", M_Addr, 0);
    rst = 1'b1;
    do_row(8'h66, 10, 1, 1'b0);
    check_row("t6 restart", 10, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
